timer_counter_nbit: RTL and testbench
=====================================

TIMER_COUNTER_NBIT -- requirements
Module: timer_counter_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/compare width (legal 8..32).
REQ-002 SHALL have parameter PRESCALE_W, default 10, prescaler counter width (at least 10).
REQ-003 SHALL have port sysClock  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port system_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  WIDTH  write data for all registers; control registers take bits [7:0].
REQ-006 SHALL have ports tcnt_we, tccr_we, ocr_we, timsk_we, tifr_we  input  1 each  register write enables.
REQ-007 SHALL have port t_pin  input  1  external clock pin, asynchronous to sysClock.
REQ-008 SHALL have port tcnt_out  output  WIDTH  current count.
REQ-009 SHALL have port ocr_out  output  WIDTH  compare register.
REQ-010 SHALL have ports tccr_out, timsk_out, tifr_out  output  8 each  control, mask and flag registers.
REQ-011 SHALL have ports irq_ovf, irq_comp  output  1 each  interrupt requests.

Function
REQ-012 TCCR fields SHALL be: [2:0] CS clock select; [3] WGM (0 normal, 1 CTC); [7] FOC force-compare strobe, never stored, reads 0; other bits stored, no effect.
REQ-013 CS SHALL select the count tick: 0 stopped, 1 every cycle, 2 /8, 3 /64, 4 /256, 5 /1024, 6 external falling edge, 7 external rising edge.
REQ-014 Prescaler SHALL be a free-running PRESCALE_W-bit counter; /N tick is asserted when its low log2(N) bits are all ones; the counter clears on any tccr_we.
REQ-015 On a tick in normal mode, TCNT SHALL increment by 1, wrap from 2^WIDTH-1 to 0, and set TIFR[0] (TOV) in the same edge.
REQ-016 On a tick with TCNT==OCR, TIFR[1] (OCF) SHALL be set; in CTC mode TCNT SHALL load 0 instead of incrementing.
REQ-017 In CTC mode with OCR=2^WIDTH-1, a tick at max SHALL set both OCF and TOV and load 0.
REQ-018 A tcnt_we SHALL load data_in and take priority over any tick in that cycle; compare match SHALL be suppressed on the next tick only.
REQ-019 A tccr_we with data_in[7]=1 SHALL set OCF on that edge regardless of count; TCNT is unaffected.
REQ-020 TIFR SHALL be write-one-to-clear on bits [1:0]; bits [7:2] SHALL read 0; a hardware set SHALL win over a clear in the same cycle.
REQ-021 irq_ovf SHALL equal TIFR[0] & TIMSK[0]; irq_comp SHALL equal TIFR[1] & TIMSK[1]; both combinational from registered state.
REQ-022 Writes to OCR and TIMSK SHALL take effect on the edge of the write; the register value is visible on the next cycle.

Reset
REQ-023 While system_reset=0, TCNT, OCR, TCCR, TIMSK, TIFR, the prescaler and the pin synchroniser SHALL be 0, and irq_ovf and irq_comp SHALL be 0.
REQ-024 Reset mid-count SHALL discard a pending tick; the first tick after release SHALL follow full prescaler periods from 0.

Configuration
REQ-025 Macro TIMER_EXT_CLK_EN defined: t_pin SHALL pass through a 2-flop synchroniser plus edge detector; CS 6/7 tick one cycle after the synchronised edge (3-cycle pin-to-tick latency).
REQ-026 Macro TIMER_EXT_CLK_EN undefined: t_pin SHALL be ignored; CS 6/7 SHALL behave as stopped; no synchroniser flops exist.

Structure
REQ-027 A shared package SHALL hold CS encodings, WGM encoding, TIFR/TIMSK bit indices and prescaler divide constants.
REQ-028 The prescaler and external-edge logic SHALL form one sub-module, timer_prescaler, outputting a single-cycle tick.

Verification
REQ-029 CS=1, normal, TCNT=0xFD, TIMSK=0x01 -> TOV set and irq_ovf=1 on the 3rd edge; TCNT=0x00.
REQ-030 CS=2, CTC, OCR=3 -> TCNT sequence 0,1,2,3,0 changing every 8 cycles; OCF set when 3->0.
REQ-031 OCF set, TIFR write 0x02 in same cycle as a new match -> OCF stays 1; next write 0x02 with no match -> OCF 0.
REQ-032 CS=1, OCR=5, tcnt_we with 5 -> no OCF on the following tick; OCF set when TCNT next equals 5.
REQ-033 TIMER_EXT_CLK_EN, CS=7, t_pin rising edges -> TCNT increments 3 cycles after each edge; macro undefined -> TCNT holds.
REQ-034 CS=5, system_reset pulsed low at prescaler 0x200 -> all outputs 0; after CS=5 rewrite, first tick 1024 cycles later.

Source files
------------

// File: rtl/timer_counter_nbit_pkg.sv
// Shared encodings for the timer: clock selects, waveform mode, flag/mask bit
// positions and prescaler divide constants.
package timer_counter_nbit_pkg;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  typedef enum logic {
    WGM_NORMAL = 1'b0,
    WGM_CTC    = 1'b1
  } wgm_e;

  localparam int TCCR_WGM_BIT = 3;
  localparam int TCCR_FOC_BIT = 7;

  localparam int TIFR_TOV   = 0;
  localparam int TIFR_OCF   = 1;
  localparam int TIMSK_TOIE = 0;
  localparam int TIMSK_OCIE = 1;

  localparam int PS_LOG2_DIV8    = 3;
  localparam int PS_LOG2_DIV64   = 6;
  localparam int PS_LOG2_DIV256  = 8;
  localparam int PS_LOG2_DIV1024 = 10;

  // True when the low lg bits of cnt are all ones.
  function automatic logic ps_hit(input logic [31:0] cnt, input int lg);
    logic [31:0] m;
    m = (32'd1 << lg) - 32'd1;
    return (cnt & m) == m;
  endfunction

endpackage

// File: rtl/timer_counter_nbit_prescaler.sv
// Free-running prescaler and optional external-pin edge detector producing a
// single-cycle count tick. External clock logic exists only with TIMER_EXT_CLK_EN.
module timer_prescaler
  import timer_counter_nbit_pkg::*;
#(
  parameter int PRESCALE_W = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  cs_e  cs_i,
  input  logic t_pin_i,
  output logic tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [31:0]           cnt32;
  logic                  ext_rise, ext_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_q + PRESCALE_W'(1);
  end

  assign cnt32 = 32'(cnt_q);

`ifdef TIMER_EXT_CLK_EN
  // [1:0] two-flop synchroniser, [2] previous synchronised level for edge detect
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], t_pin_i};
  end

  assign ext_rise = sync_q[1] & ~sync_q[2];
  assign ext_fall = ~sync_q[1] & sync_q[2];
`else
  logic unused_t_pin;
  assign unused_t_pin = t_pin_i;
  assign ext_rise     = 1'b0;
  assign ext_fall     = 1'b0;
`endif

  always_comb begin
    tick_o = 1'b0;
    unique case (cs_i)
      CS_STOP:     tick_o = 1'b0;
      CS_DIV1:     tick_o = 1'b1;
      CS_DIV8:     tick_o = ps_hit(cnt32, PS_LOG2_DIV8);
      CS_DIV64:    tick_o = ps_hit(cnt32, PS_LOG2_DIV64);
      CS_DIV256:   tick_o = ps_hit(cnt32, PS_LOG2_DIV256);
      CS_DIV1024:  tick_o = ps_hit(cnt32, PS_LOG2_DIV1024);
      CS_EXT_FALL: tick_o = ext_fall;
      CS_EXT_RISE: tick_o = ext_rise;
      default:     tick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer_counter_nbit.sv
// N-bit timer/counter with compare, CTC mode, overflow/compare flags and IRQs.
// External pin clocking (CS 6/7) is built only when TIMER_EXT_CLK_EN is defined.
module timer_counter_nbit
  import timer_counter_nbit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 10
) (
  input  logic             sysClock,
  input  logic             system_reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             tcnt_we,
  input  logic             tccr_we,
  input  logic             ocr_we,
  input  logic             timsk_we,
  input  logic             tifr_we,
  input  logic             t_pin,
  output logic [WIDTH-1:0] tcnt_out,
  output logic [WIDTH-1:0] ocr_out,
  output logic [7:0]       tccr_out,
  output logic [7:0]       timsk_out,
  output logic [7:0]       tifr_out,
  output logic             irq_ovf,
  output logic             irq_comp
);

  localparam logic [WIDTH-1:0] TCNT_MAX = '1;

  logic [WIDTH-1:0] tcnt_q, tcnt_d, ocr_q;
  logic [6:0]       tccr_q;
  logic [7:0]       timsk_q;
  logic [1:0]       tifr_q, tifr_d, flag_set, flag_clr;
  logic             supp_q, supp_d;
  logic             tick, match;
  cs_e              cs;
  wgm_e             wgm;

  assign cs  = cs_e'(tccr_q[2:0]);
  assign wgm = wgm_e'(tccr_q[TCCR_WGM_BIT]);

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i   (sysClock),
    .rst_ni  (system_reset),
    .clr_i   (tccr_we),
    .cs_i    (cs),
    .t_pin_i (t_pin),
    .tick_o  (tick)
  );

  // supp_q masks the compare on the first tick after a software TCNT load
  assign match = (tcnt_q == ocr_q) && !supp_q;

  always_comb begin
    tcnt_d   = tcnt_q;
    supp_d   = supp_q;
    flag_set = '0;
    flag_clr = '0;
    if (tcnt_we) begin
      tcnt_d = data_in;
      supp_d = 1'b1;
    end else if (tick) begin
      supp_d = 1'b0;
      if (match)              flag_set[TIFR_OCF] = 1'b1;
      if (tcnt_q == TCNT_MAX) flag_set[TIFR_TOV] = 1'b1;
      if (wgm == WGM_CTC && match) tcnt_d = '0;
      else                         tcnt_d = tcnt_q + WIDTH'(1);
    end
    if (tccr_we && data_in[TCCR_FOC_BIT]) flag_set[TIFR_OCF] = 1'b1;
    if (tifr_we) flag_clr = data_in[1:0];
    tifr_d = (tifr_q & ~flag_clr) | flag_set;
  end

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tccr_q  <= '0;
      timsk_q <= '0;
      tifr_q  <= '0;
      supp_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      supp_q <= supp_d;
      tifr_q <= tifr_d;
      if (ocr_we)   ocr_q   <= data_in;
      if (tccr_we)  tccr_q  <= data_in[6:0];
      if (timsk_we) timsk_q <= data_in[7:0];
    end
  end

  assign tcnt_out  = tcnt_q;
  assign ocr_out   = ocr_q;
  assign tccr_out  = {1'b0, tccr_q};
  assign timsk_out = timsk_q;
  assign tifr_out  = {6'b0, tifr_q};
  assign irq_ovf   = tifr_q[TIFR_TOV] & timsk_q[TIMSK_TOIE];
  assign irq_comp  = tifr_q[TIFR_OCF] & timsk_q[TIMSK_OCIE];

endmodule

// File: tb/tb_timer_counter_nbit.sv
// Scoreboard bench for timer_counter_nbit: directed writes queue expected
// register values tagged with a cycle; a negedge monitor pops and compares.
module tb_timer_counter_nbit;

  localparam int W = 8;
  localparam int F_TCNT = 0, F_TIFR = 1, F_OVF = 2, F_CMP = 3, F_OCR = 4, F_TCCR = 5, F_TIMSK = 6;
  localparam int K_TCNT = 0, K_TCCR = 1, K_OCR = 2, K_TIMSK = 3, K_TIFR = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         tcnt_we = 0, tccr_we = 0, ocr_we = 0, timsk_we = 0, tifr_we = 0, t_pin = 0;
  logic [W-1:0] tcnt_out, ocr_out;
  logic [7:0]   tccr_out, timsk_out, tifr_out;
  logic         irq_ovf, irq_comp;

  timer_counter_nbit #(.WIDTH(W), .PRESCALE_W(10)) dut (
    .sysClock(clk), .system_reset(rst_n), .data_in(din),
    .tcnt_we(tcnt_we), .tccr_we(tccr_we), .ocr_we(ocr_we), .timsk_we(timsk_we), .tifr_we(tifr_we),
    .t_pin(t_pin), .tcnt_out(tcnt_out), .ocr_out(ocr_out), .tccr_out(tccr_out),
    .timsk_out(timsk_out), .tifr_out(tifr_out), .irq_ovf(irq_ovf), .irq_comp(irq_comp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;

  function automatic logic [31:0] fsel(input int f);
    case (f)
      F_TCNT:  return 32'(tcnt_out);
      F_TIFR:  return 32'(tifr_out);
      F_OVF:   return 32'(irq_ovf);
      F_CMP:   return 32'(irq_comp);
      F_OCR:   return 32'(ocr_out);
      F_TCCR:  return 32'(tccr_out);
      F_TIMSK: return 32'(timsk_out);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = fsel(e.fld);
      checks++;
      if (e.cyc != cyc || a !== e.val) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got %0h, want %0h", e.nm, cyc, e.cyc, a, e.val);
      end
    end
  end

  task automatic push(input int c, input int f, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wr(input int k, input logic [W-1:0] v);
    din = v;
    case (k)
      K_TCNT:  tcnt_we  = 1'b1;
      K_TCCR:  tccr_we  = 1'b1;
      K_OCR:   ocr_we   = 1'b1;
      K_TIMSK: timsk_we = 1'b1;
      default: tifr_we  = 1'b1;
    endcase
    step(1);
    {tcnt_we, tccr_we, ocr_we, timsk_we, tifr_we} = '0;
  endtask

  initial begin
    int c0, t0, p, g, h, q, r;
`ifdef TIMER_EXT_CLK_EN
    bit ext = 1'b1;
`else
    bit ext = 1'b0;
`endif

    step(2);
    push(cyc, F_TCNT, 0, "rst_tcnt");  push(cyc, F_TIFR, 0, "rst_tifr");
    push(cyc, F_OVF, 0, "rst_irq_ovf"); push(cyc, F_CMP, 0, "rst_irq_comp");
    push(cyc, F_TCCR, 0, "rst_tccr");
    rst_n = 1'b1;
    step(1);

    // Overflow at 0xFF -> 0x00 with CS=1
    wr(K_TCNT, 8'hFD); wr(K_TIMSK, 8'h01); wr(K_TCCR, 8'h01); c0 = cyc;
    push(c0,   F_TIMSK, 1,     "timsk_rd");
    push(c0+1, F_TCNT, 8'hFE, "ovf_e1");
    push(c0+2, F_TCNT, 8'hFF, "ovf_e2");   push(c0+2, F_TIFR, 0, "ovf_e2_flag");
    push(c0+3, F_TCNT, 8'h00, "ovf_e3");   push(c0+3, F_TIFR, 1, "ovf_tov");
    push(c0+3, F_OVF, 1, "ovf_irq");       push(c0+3, F_CMP, 0, "ovf_no_comp");
    goto(c0+3); wr(K_TCCR, 8'h00);
    push(c0+4, F_TCNT, 1, "stop_last_tick"); push(c0+4, F_TIFR, 3, "match_at_zero");
    wr(K_TIFR, 8'h03);
    push(cyc, F_TIFR, 0, "w1c_both"); push(cyc, F_OVF, 0, "irq_ovf_clr");

    // CTC at /8 with OCR=3
    wr(K_OCR, 8'd3); wr(K_TCNT, 8'd0); wr(K_TCCR, 8'h0A); t0 = cyc;
    push(t0+1,  F_TCCR, 8'h0A, "tccr_rd");
    push(t0+7,  F_TCNT, 0, "ctc_t7");   push(t0+8,  F_TCNT, 1, "ctc_t8");
    push(t0+15, F_TCNT, 1, "ctc_t15");  push(t0+16, F_TCNT, 2, "ctc_t16");
    push(t0+24, F_TCNT, 3, "ctc_t24");  push(t0+24, F_TIFR, 0, "ctc_noflag");
    push(t0+32, F_TCNT, 0, "ctc_wrap"); push(t0+32, F_TIFR, 2, "ctc_ocf");

    // Hardware set beats W1C in the same cycle
    goto(t0+63); wr(K_TIFR, 8'h02);
    push(t0+64, F_TIFR, 2, "set_wins_clr"); push(t0+64, F_TCNT, 0, "ctc_wrap2");
    wr(K_TIFR, 8'h02);
    push(t0+65, F_TIFR, 0, "ocf_clr");

    // Force compare strobe
    wr(K_TCCR, 8'h00); wr(K_TCCR, 8'h80);
    push(cyc, F_TIFR, 2, "foc_ocf"); push(cyc, F_TCCR, 0, "foc_not_stored"); push(cyc, F_TCNT, 0, "foc_tcnt");
    wr(K_TIFR, 8'h03);

    // Compare suppressed on the tick after a TCNT write
    wr(K_OCR, 8'd5); wr(K_TCNT, 8'd5); wr(K_TCCR, 8'h01); p = cyc;
    push(p+1,   F_TCNT, 6, "supp_cnt");    push(p+1,   F_TIFR, 0, "supp_noocf");
    push(p+251, F_TCNT, 0, "supp_wrap");   push(p+251, F_TIFR, 1, "supp_tov");
    push(p+256, F_TCNT, 5, "supp_at5");    push(p+256, F_TIFR, 1, "supp_at5_flag");
    push(p+257, F_TCNT, 6, "supp_after");  push(p+257, F_TIFR, 3, "supp_ocf");
    push(p+257, F_CMP, 0, "comp_masked");
    goto(p+257); wr(K_TIMSK, 8'h03);
    push(p+258, F_CMP, 1, "comp_irq"); push(p+258, F_OVF, 1, "ovf_irq2"); push(p+258, F_TCNT, 7, "cnt7");
    wr(K_TCCR, 8'h00);
    push(p+259, F_TCNT, 8, "stop_cnt8");
    wr(K_TIFR, 8'h03); wr(K_TIMSK, 8'h00);

    // CTC with OCR at max: OCF and TOV together, load 0
    wr(K_OCR, 8'hFF); wr(K_TCNT, 8'hFE); wr(K_TCCR, 8'h09); g = cyc;
    push(g+1, F_TCNT, 8'hFF, "ctcmax_ff"); push(g+1, F_TIFR, 0, "ctcmax_noflag");
    push(g+2, F_TCNT, 0, "ctcmax_zero");   push(g+2, F_TIFR, 3, "ctcmax_both");
    goto(g+2); wr(K_TCCR, 8'h00);
    push(g+3, F_TCNT, 1, "ctcmax_stop");
    wr(K_TIFR, 8'h03);

    // External pin clocking
    wr(K_TCCR, 8'h07); h = cyc; t_pin = 1'b1;
    push(h+2, F_TCNT, 1, "ext_rise_pre");
    push(h+3, F_TCNT, ext ? 2 : 1, "ext_rise1");
    goto(h+5);  t_pin = 1'b0;
    goto(h+10); t_pin = 1'b1;
    push(h+12, F_TCNT, ext ? 2 : 1, "ext_fall_ignored");
    push(h+13, F_TCNT, ext ? 3 : 1, "ext_rise2");
    goto(h+13); wr(K_TCCR, 8'h06);
    goto(h+15); t_pin = 1'b0;
    push(h+17, F_TCNT, ext ? 3 : 1, "ext_fall_pre");
    push(h+18, F_TCNT, ext ? 4 : 1, "ext_fall");
    wr(K_TCCR, 8'h00);

    // Reset mid-count at prescaler 0x200, then a full 1024-cycle period
    wr(K_TIMSK, 8'h03); wr(K_TCCR, 8'h85); q = cyc;
    push(q, F_TIFR, 2, "pre_rst_ocf"); push(q, F_CMP, 1, "pre_rst_irq");
    goto(q+512); rst_n = 1'b0;
    push(q+512, F_TCNT, 0, "rst2_tcnt");  push(q+512, F_OCR, 0, "rst2_ocr");
    push(q+512, F_TCCR, 0, "rst2_tccr");  push(q+512, F_TIMSK, 0, "rst2_timsk");
    push(q+512, F_TIFR, 0, "rst2_tifr");  push(q+512, F_OVF, 0, "rst2_ovf");
    push(q+512, F_CMP, 0, "rst2_comp");
    step(2); rst_n = 1'b1; step(1);
    wr(K_TCCR, 8'h05); r = cyc;
    push(r+1023, F_TCNT, 0, "div1024_pre"); push(r+1023, F_TIFR, 0, "div1024_pre_flag");
    push(r+1024, F_TCNT, 1, "div1024_tick"); push(r+1024, F_TIFR, 2, "div1024_ocf");
    goto(r+1025);

    step(5);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
